// File: rtl/spi_master_seq_if.sv
// Bus/SPI handshake bundle for spi_master_seq; master = driver side, slave = sequencer side.
// Optional rx_ovf/ovf_clr signals exist only when SPI_SEQ_RX_OVF_EN is defined.
interface spi_master_seq_if;
    logic       en;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic       tx_empty;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_full;
    logic       rx_empty;
    logic       busy;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_req_ack;
    logic [7:0] rx_data;
`ifdef SPI_SEQ_RX_OVF_EN
    logic       rx_ovf;
    logic       ovf_clr;

    modport master (
        output en, flush, wr_en, wr_data, rd_en, tx_req_ack, rx_data, ovf_clr,
        input  tx_full, tx_empty, rd_data, rx_full, rx_empty, busy, tx_req, tx_data, rx_ovf
    );
    modport slave (
        input  en, flush, wr_en, wr_data, rd_en, tx_req_ack, rx_data, ovf_clr,
        output tx_full, tx_empty, rd_data, rx_full, rx_empty, busy, tx_req, tx_data, rx_ovf
    );
`else
    modport master (
        output en, flush, wr_en, wr_data, rd_en, tx_req_ack, rx_data,
        input  tx_full, tx_empty, rd_data, rx_full, rx_empty, busy, tx_req, tx_data
    );
    modport slave (
        input  en, flush, wr_en, wr_data, rd_en, tx_req_ack, rx_data,
        output tx_full, tx_empty, rd_data, rx_full, rx_empty, busy, tx_req, tx_data
    );
`endif
endinterface

// File: rtl/spi_master_seq.sv
// Byte sequencer feeding an SPI master from a TX FIFO and collecting replies into an RX FIFO.
// Optional macro SPI_SEQ_RX_OVF_EN: transfers proceed when RX is full, dropping bytes and flagging rx_ovf.
module spi_master_seq #(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    spi_master_seq_if.slave sif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_tx_mem [DEPTH];
    logic [AW-1:0]   r_tx_wptr;
    logic [AW-1:0]   r_tx_rptr;
    logic [CW-1:0]   r_tx_cnt;
    logic [7:0]      r_rx_mem [DEPTH];
    logic [AW-1:0]   r_rx_wptr;
    logic [AW-1:0]   r_rx_rptr;
    logic [CW-1:0]   r_rx_cnt;

    logic            r_tx_req;
    logic [7:0]      r_tx_data;

    logic            w_tx_full;
    logic            w_tx_empty;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic            w_can_start;
    logic            w_start;
    logic            w_flush;
    logic            w_ack;
    logic            w_tx_push;
    logic            w_tx_pop;
    logic            w_rx_push;
    logic            w_rx_pop;

    assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
    assign w_rx_empty = (r_rx_cnt == '0);

`ifdef SPI_SEQ_RX_OVF_EN
    assign w_can_start = sif.en && !w_tx_empty && !sif.tx_req_ack;
`else
    assign w_can_start = sif.en && !w_tx_empty && !sif.tx_req_ack && !w_rx_full;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_flush     = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end else if (sif.flush) begin
                    w_flush = 1'b1;
                end
            end
            REQ: begin
                if (sif.tx_req_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = REL;
                end
            end
            REL: begin
                if (!sif.tx_req_ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A write against a full FIFO is dropped even if the sequencer pops in the same cycle.
    assign w_tx_push = sif.wr_en && !w_tx_full && !w_flush;
    assign w_tx_pop  = w_start;
    assign w_rx_push = w_ack && !w_rx_full;
    assign w_rx_pop  = sif.rd_en && !w_rx_empty && !w_flush;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_tx_req <= (w_state_nxt == REQ);
            if (w_start) r_tx_data <= r_tx_mem[r_tx_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || w_flush) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= sif.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn || w_flush) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= sif.rx_data;
    end

`ifdef SPI_SEQ_RX_OVF_EN
    logic r_rx_ovf;
    logic w_ovf_set;

    assign w_ovf_set = w_ack && w_rx_full;

    always_ff @(posedge clk) begin
        if (!resetn)          r_rx_ovf <= 1'b0;
        else if (w_ovf_set)   r_rx_ovf <= 1'b1;
        else if (sif.ovf_clr) r_rx_ovf <= 1'b0;
    end

    assign sif.rx_ovf = r_rx_ovf;
`endif

    // Head is masked when empty so stale memory never shows after reset or flush.
    assign sif.rd_data  = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
    assign sif.tx_full  = w_tx_full;
    assign sif.tx_empty = w_tx_empty;
    assign sif.rx_full  = w_rx_full;
    assign sif.rx_empty = w_rx_empty;
    assign sif.busy     = (r_state != IDLE) || !w_tx_empty;
    assign sif.tx_req   = r_tx_req;
    assign sif.tx_data  = r_tx_data;
endmodule

// File: tb/tb_spi_master_seq.sv
// Directed testbench for spi_master_seq; the bench acts as both bus writer and SPI master.
module tb_spi_master_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    spi_master_seq_if sif ();

    spi_master_seq #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sif    (sif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b);
        sif.wr_en   = 1'b1;
        sif.wr_data = b;
        @(negedge clk);
        sif.wr_en   = 1'b0;
    endtask

    task automatic pop_byte();
        sif.rd_en = 1'b1;
        @(negedge clk);
        sif.rd_en = 1'b0;
    endtask

    // Acts as the SPI master: waits (bounded) for tx_req, acks after dly cycles, then releases.
    task automatic serve(input logic [7:0] rxb, input int dly, output logic [7:0] sent, output bit ok);
        int k = 0;
        while (!sif.tx_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!sif.tx_req) begin
            ok   = 1'b0;
            sent = '0;
        end else begin
            ok   = 1'b1;
            sent = sif.tx_data;
            repeat (dly) @(negedge clk);
            sif.tx_req_ack = 1'b1;
            sif.rx_data    = rxb;
            @(negedge clk);
            sif.tx_req_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (sif.tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b expected 0", sif.tx_req); end
        n_tests++; if (sif.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", sif.tx_data); end
        n_tests++; if ({sif.tx_empty, sif.rx_empty, sif.tx_full, sif.rx_full} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 1100", {sif.tx_empty, sif.rx_empty, sif.tx_full, sif.rx_full}); end
        n_tests++; if (sif.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", sif.rd_data); end
        n_tests++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", sif.busy); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        int bad = 0;
        sif.en = 1'b1;
        push_byte(8'hA5);
        n_tests++; if (sif.tx_empty !== 1'b0 || sif.tx_req !== 1'b0) begin
            n_fail++; $display("FAIL single_wr_latency: got tx_empty=%b tx_req=%b expected 0 0", sif.tx_empty, sif.tx_req); end
        @(negedge clk);
        n_tests++; if (sif.tx_req !== 1'b1 || sif.tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL single_req: got tx_req=%b tx_data=%h expected 1 a5", sif.tx_req, sif.tx_data); end
        n_tests++; if (sif.tx_empty !== 1'b1 || sif.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_pop: got tx_empty=%b busy=%b expected 1 1", sif.tx_empty, sif.busy); end
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (sif.tx_req !== 1'b1 || sif.tx_data !== 8'hA5) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL single_hold: got %0d unstable cycles expected 0", bad); end
        sif.tx_req_ack = 1'b1;
        sif.rx_data    = 8'h3C;
        @(negedge clk);
        n_tests++; if (sif.tx_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b expected 0", sif.tx_req); end
        n_tests++; if (sif.rx_empty !== 1'b0 || sif.rd_data !== 8'h3C) begin
            n_fail++; $display("FAIL single_rx: got rx_empty=%b rd_data=%h expected 0 3c", sif.rx_empty, sif.rd_data); end
        sif.tx_req_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", sif.busy); end
        pop_byte();
        n_tests++; if (sif.rx_empty !== 1'b1 || sif.rd_data !== 8'h00) begin
            n_fail++; $display("FAIL single_rd: got rx_empty=%b rd_data=%h expected 1 00", sif.rx_empty, sif.rd_data); end
    endtask

    task automatic test_burst();
        logic [7:0] sent;
        bit ok;
        sif.en = 1'b0;
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        n_tests++; if (sif.tx_full !== 1'b1) begin n_fail++; $display("FAIL burst_full: got %b expected 1", sif.tx_full); end
        push_byte(8'hFF);
        n_tests++; if (sif.tx_full !== 1'b1 || sif.tx_req !== 1'b0) begin
            n_fail++; $display("FAIL burst_en_off: got tx_full=%b tx_req=%b expected 1 0", sif.tx_full, sif.tx_req); end
        sif.en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            serve(8'(i), 2, sent, ok);
            n_tests++; if (!ok || sent !== 8'(i)) begin
                n_fail++; $display("FAIL burst_tx_%0d: got ok=%b tx_data=%h expected 1 %h", i, ok, sent, 8'(i)); end
        end
        n_tests++; if (sif.tx_empty !== 1'b1 || sif.busy !== 1'b0 || sif.rx_full !== 1'b1) begin
            n_fail++; $display("FAIL burst_end_flags: got tx_empty=%b busy=%b rx_full=%b expected 1 0 1", sif.tx_empty, sif.busy, sif.rx_full); end
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (sif.rd_data !== 8'(i)) begin n_fail++; $display("FAIL burst_rx_%0d: got %h expected %h", i, sif.rd_data, 8'(i)); end
            pop_byte();
        end
        n_tests++; if (sif.rx_empty !== 1'b1) begin n_fail++; $display("FAIL burst_rx_empty: got %b expected 1", sif.rx_empty); end
    endtask

`ifndef SPI_SEQ_RX_OVF_EN
    task automatic test_rx_stall();
        logic [7:0] sent;
        bit ok;
        int hi = 0;
        int k = 0;
        logic [7:0] exp_rx [4];
        sif.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h10 + 8'(i));
            serve(8'hC0 + 8'(i), 1, sent, ok);
            n_tests++; if (!ok || sent !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL stall_fill_%0d: got ok=%b tx_data=%h expected 1 %h", i, ok, sent, 8'h10 + 8'(i)); end
        end
        n_tests++; if (sif.rx_full !== 1'b1) begin n_fail++; $display("FAIL stall_rx_full: got %b expected 1", sif.rx_full); end
        push_byte(8'h55);
        for (int i = 0; i < 6; i++) begin
            if (sif.tx_req !== 1'b0) hi++;
            @(negedge clk);
        end
        n_tests++; if (hi != 0 || sif.tx_empty !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold: got req_cycles=%0d tx_empty=%b expected 0 0", hi, sif.tx_empty); end
        pop_byte();
        n_tests++; if (sif.rd_data !== 8'hC1) begin n_fail++; $display("FAIL stall_rd: got %h expected c1", sif.rd_data); end
        while (!sif.tx_req && k < 2) begin
            @(negedge clk);
            k++;
        end
        n_tests++; if (sif.tx_req !== 1'b1 || sif.tx_data !== 8'h55) begin
            n_fail++; $display("FAIL stall_resume: got tx_req=%b tx_data=%h expected 1 55", sif.tx_req, sif.tx_data); end
        serve(8'hAA, 0, sent, ok);
        exp_rx[0] = 8'hC1; exp_rx[1] = 8'hC2; exp_rx[2] = 8'hC3; exp_rx[3] = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (sif.rd_data !== exp_rx[i]) begin n_fail++; $display("FAIL stall_drain_%0d: got %h expected %h", i, sif.rd_data, exp_rx[i]); end
            pop_byte();
        end
    endtask
`else
    task automatic test_overflow();
        logic [7:0] sent;
        bit ok;
        sif.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h10 + 8'(i));
            serve(8'hC0 + 8'(i), 1, sent, ok);
        end
        n_tests++; if (sif.rx_full !== 1'b1 || sif.rx_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_pre: got rx_full=%b rx_ovf=%b expected 1 0", sif.rx_full, sif.rx_ovf); end
        push_byte(8'h77);
        serve(8'hEE, 2, sent, ok);
        n_tests++; if (!ok || sent !== 8'h77) begin n_fail++; $display("FAIL ovf_xfer: got ok=%b tx_data=%h expected 1 77", ok, sent); end
        n_tests++; if (sif.rx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", sif.rx_ovf); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (sif.rd_data !== 8'hC0 + 8'(i)) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, sif.rd_data, 8'hC0 + 8'(i)); end
            pop_byte();
        end
        n_tests++; if (sif.rx_empty !== 1'b1 || sif.rx_ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got rx_empty=%b rx_ovf=%b expected 1 1", sif.rx_empty, sif.rx_ovf); end
        sif.ovf_clr = 1'b1;
        @(negedge clk);
        sif.ovf_clr = 1'b0;
        n_tests++; if (sif.rx_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", sif.rx_ovf); end
    endtask
`endif

    task automatic test_en_flush();
        int k = 0;
        int hi = 0;
        sif.en = 1'b0;
        push_byte(8'h33);
        push_byte(8'h44);
        sif.en = 1'b1;
        while (!sif.tx_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_tests++; if (sif.tx_req !== 1'b1 || sif.tx_data !== 8'h33) begin
            n_fail++; $display("FAIL enf_start: got tx_req=%b tx_data=%h expected 1 33", sif.tx_req, sif.tx_data); end
        sif.en    = 1'b0;
        sif.flush = 1'b1;
        @(negedge clk);
        sif.flush = 1'b0;
        n_tests++; if (sif.tx_req !== 1'b1 || sif.tx_empty !== 1'b0 || sif.tx_data !== 8'h33) begin
            n_fail++; $display("FAIL enf_midxfer: got tx_req=%b tx_empty=%b tx_data=%h expected 1 0 33", sif.tx_req, sif.tx_empty, sif.tx_data); end
        sif.tx_req_ack = 1'b1;
        sif.rx_data    = 8'h90;
        @(negedge clk);
        sif.tx_req_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sif.tx_req !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0 || sif.rd_data !== 8'h90) begin
            n_fail++; $display("FAIL enf_blocked: got req_cycles=%0d rd_data=%h expected 0 90", hi, sif.rd_data); end
        n_tests++; if (sif.busy !== 1'b1) begin n_fail++; $display("FAIL enf_busy_queued: got %b expected 1", sif.busy); end
        sif.flush = 1'b1;
        @(negedge clk);
        sif.flush = 1'b0;
        n_tests++; if (sif.tx_empty !== 1'b1 || sif.rx_empty !== 1'b1 || sif.busy !== 1'b0) begin
            n_fail++; $display("FAIL enf_flush: got tx_empty=%b rx_empty=%b busy=%b expected 1 1 0", sif.tx_empty, sif.rx_empty, sif.busy); end
        sif.en = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sif.tx_req !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL enf_after_flush: got req_cycles=%0d expected 0", hi); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] sent;
        bit ok;
        int k = 0;
        sif.en = 1'b1;
        push_byte(8'h5B);
        serve(8'h66, 1, sent, ok);
        push_byte(8'h5A);
        while (!sif.tx_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_tests++; if (sif.tx_req !== 1'b1 || sif.rx_empty !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pre: got tx_req=%b rx_empty=%b expected 1 0", sif.tx_req, sif.rx_empty); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_tests++; if (sif.tx_req !== 1'b0 || sif.tx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_req: got tx_req=%b tx_data=%h expected 0 00", sif.tx_req, sif.tx_data); end
        n_tests++; if ({sif.tx_empty, sif.rx_empty, sif.tx_full, sif.rx_full} !== 4'b1100 || sif.rd_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_flags: got %b rd_data=%h expected 1100 00", {sif.tx_empty, sif.rx_empty, sif.tx_full, sif.rx_full}, sif.rd_data); end
        @(negedge clk);
        n_tests++; if (sif.busy !== 1'b0 || sif.tx_req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: got busy=%b tx_req=%b expected 0 0", sif.busy, sif.tx_req); end
    endtask

    initial begin
        sif.en         = 1'b0;
        sif.flush      = 1'b0;
        sif.wr_en      = 1'b0;
        sif.wr_data    = 8'h00;
        sif.rd_en      = 1'b0;
        sif.tx_req_ack = 1'b0;
        sif.rx_data    = 8'h00;
`ifdef SPI_SEQ_RX_OVF_EN
        sif.ovf_clr    = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_burst();
`ifdef SPI_SEQ_RX_OVF_EN
        test_overflow();
`else
        test_rx_stall();
`endif
        test_en_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
